// File: rtl/conj_discrim_pkg.sv
// Shared helpers for the conjugate-product discriminator: channel-index width,
// saturation to an arbitrary signed width and {imag,real} packing.
package conj_discrim_pkg;

    localparam int MAXW = 64;

    function automatic int calc_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Clamp a sign-extended value to the signed range of out_w bits.
    function automatic logic signed [MAXW-1:0] saturate(input logic signed [MAXW-1:0] x,
                                                        input int out_w);
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (x > hi) begin
            saturate = hi;
        end else if (x < lo) begin
            saturate = lo;
        end else begin
            saturate = x;
        end
    endfunction

    // Returns {imag, real} in the low 2*w bits; callers slice what they need.
    function automatic logic [2*MAXW-1:0] pack_cplx(input logic [MAXW-1:0] re,
                                                    input logic [MAXW-1:0] im,
                                                    input int w);
        logic [MAXW-1:0] mask;
        mask = (64'd1 << w) - 64'd1;
        pack_cplx = ({64'd0, im & mask} << w) | {64'd0, re & mask};
    endfunction

endpackage

// File: rtl/conj_mult_stage.sv
// First pipeline stage: registers the four signed cross products of cur and
// prev, the "history invalid" zero flag and the beat's sideband.
module conj_mult_stage #(
    parameter int W  = 16,
    parameter int CW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  in_valid,
    input  logic [2*W-1:0]        cur,
    input  logic [2*W-1:0]        prev,
    input  logic                  prev_valid,
    input  logic [(2*W)/8-1:0]    in_strb,
    input  logic                  in_last,
    input  logic [CW-1:0]         in_user,
    output logic                  valid,
    output logic                  zero,
    output logic signed [2*W-1:0] ac,
    output logic signed [2*W-1:0] bd,
    output logic signed [2*W-1:0] bc,
    output logic signed [2*W-1:0] ad,
    output logic [(2*W)/8-1:0]    strb,
    output logic                  last,
    output logic [CW-1:0]         user
);

    logic signed [W-1:0] a, b, c, d;

    assign a = $signed(cur[W-1:0]);
    assign b = $signed(cur[2*W-1:W]);
    assign c = $signed(prev[W-1:0]);
    assign d = $signed(prev[2*W-1:W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            zero  <= 1'b0;
            ac    <= '0;
            bd    <= '0;
            bc    <= '0;
            ad    <= '0;
            strb  <= '0;
            last  <= 1'b0;
            user  <= '0;
        end else if (load) begin
            valid <= in_valid;
            if (in_valid) begin
                zero <= !prev_valid;
                ac   <= a * c;
                bd   <= b * d;
                bc   <= b * c;
                ad   <= a * d;
                strb <= in_strb;
                last <= in_last;
                user <= in_user;
            end
        end
    end

endmodule

// File: rtl/conj_discrim.sv
// Conjugate-product FM discriminator: out = sat((cur * conj(prev)) >>> OUT_SHIFT)
// per interleaved channel, two-stage AXI-Stream pipeline with full backpressure.
module conj_discrim
    import conj_discrim_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int NUM_CH        = 1,
    parameter int OUT_SHIFT     = 15,
    parameter int CLEAR_ON_LAST = 1,
    localparam int W  = SAMPLE_WIDTH,
    localparam int DW = 2 * SAMPLE_WIDTH,
    localparam int CW = calc_cw(NUM_CH)
) (
    input  logic            s00_axis_aclk,
    input  logic            s00_axis_aresetn,
    input  logic            s00_axis_tvalid,
    output logic            s00_axis_tready,
    input  logic [DW-1:0]   s00_axis_tdata,
    input  logic [DW/8-1:0] s00_axis_tstrb,
    input  logic            s00_axis_tlast,
    output logic            m00_axis_tvalid,
    input  logic            m00_axis_tready,
    output logic [DW-1:0]   m00_axis_tdata,
    output logic [DW/8-1:0] m00_axis_tstrb,
    output logic            m00_axis_tlast,
    output logic [CW-1:0]   m00_axis_tuser
);

    localparam int NSLOT = 1 << CW;

    logic                 s1_load, s2_load, accept;
    logic [CW-1:0]        ch;
    logic [DW-1:0]        hist [NSLOT];
    logic [NSLOT-1:0]     hvalid;

    logic                 s1_valid, s1_zero, s1_last;
    logic signed [DW-1:0] s1_ac, s1_bd, s1_bc, s1_ad;
    logic [DW/8-1:0]      s1_strb;
    logic [CW-1:0]        s1_user;

    logic signed [DW:0]      sum_re, sum_im, sh_re, sh_im;
    logic signed [MAXW-1:0]  sat_re, sat_im;
    logic [2*MAXW-1:0]       packed_out;
    logic                    unused_bits;

    // Valid/ready: a beat moves on a cycle where valid && ready; S2 frees when
    // the consumer takes its word, S1 frees when empty or S2 frees.
    assign s2_load         = !m00_axis_tvalid || m00_axis_tready;
    assign s1_load         = !s1_valid || s2_load;
    assign s00_axis_tready = s00_axis_aresetn && s1_load;
    assign accept          = s00_axis_tvalid && s00_axis_tready;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            ch     <= '0;
            hvalid <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            hist[ch] <= s00_axis_tdata;
            // The stage-1 read of hist/hvalid happened this cycle, so clearing
            // here only affects later beats.
            if (CLEAR_ON_LAST != 0 && s00_axis_tlast) begin
                hvalid <= '0;
            end else begin
                hvalid[ch] <= 1'b1;
            end
            if (s00_axis_tlast || ch == CW'(NUM_CH - 1)) begin
                ch <= '0;
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

    conj_mult_stage #(
        .W  (W),
        .CW (CW)
    ) u_mult (
        .clk        (s00_axis_aclk),
        .rst_n      (s00_axis_aresetn),
        .load       (s1_load),
        .in_valid   (accept),
        .cur        (s00_axis_tdata),
        .prev       (hist[ch]),
        .prev_valid (hvalid[ch]),
        .in_strb    (s00_axis_tstrb),
        .in_last    (s00_axis_tlast),
        .in_user    (ch),
        .valid      (s1_valid),
        .zero       (s1_zero),
        .ac         (s1_ac),
        .bd         (s1_bd),
        .bc         (s1_bc),
        .ad         (s1_ad),
        .strb       (s1_strb),
        .last       (s1_last),
        .user       (s1_user)
    );

    always_comb begin
        sum_re     = {s1_ac[DW-1], s1_ac} + {s1_bd[DW-1], s1_bd};
        sum_im     = {s1_bc[DW-1], s1_bc} - {s1_ad[DW-1], s1_ad};
        sh_re      = sum_re >>> OUT_SHIFT;
        sh_im      = sum_im >>> OUT_SHIFT;
        sat_re     = saturate({{(MAXW-DW-1){sh_re[DW]}}, sh_re}, W);
        sat_im     = saturate({{(MAXW-DW-1){sh_im[DW]}}, sh_im}, W);
        packed_out = pack_cplx(sat_re, sat_im, W);
    end

    assign unused_bits = ^packed_out[2*MAXW-1:DW];

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= '0;
        end else if (s2_load) begin
            m00_axis_tvalid <= s1_valid;
            if (s1_valid) begin
                m00_axis_tdata <= s1_zero ? '0 : packed_out[DW-1:0];
                m00_axis_tstrb <= s1_strb;
                m00_axis_tlast <= s1_last;
                m00_axis_tuser <= s1_user;
            end
        end
    end

endmodule

// File: tb/tb_conj_discrim.sv
// Bench for conj_discrim: directed plan cases plus randomized backpressure
// against an integer-arithmetic reference model, on NUM_CH=1 and NUM_CH=2 instances.
module tb_conj_discrim;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sel;
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_strb;

    logic        v1, r1, mv1, mr1, ml1, mu1;
    logic [31:0] md1;
    logic [3:0]  ms1;
    logic        v2, r2, mv2, mr2, ml2, mu2;
    logic [31:0] md2;
    logic [3:0]  ms2;

    assign v1  = in_valid && !sel;
    assign v2  = in_valid && sel;
    assign mr1 = sel ? 1'b1 : out_ready;
    assign mr2 = sel ? out_ready : 1'b1;

    conj_discrim #(.SAMPLE_WIDTH(16), .NUM_CH(1), .OUT_SHIFT(15), .CLEAR_ON_LAST(1)) dut1 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(v1), .s00_axis_tready(r1), .s00_axis_tdata(in_data),
        .s00_axis_tstrb(in_strb), .s00_axis_tlast(in_last),
        .m00_axis_tvalid(mv1), .m00_axis_tready(mr1), .m00_axis_tdata(md1),
        .m00_axis_tstrb(ms1), .m00_axis_tlast(ml1), .m00_axis_tuser(mu1)
    );

    conj_discrim #(.SAMPLE_WIDTH(16), .NUM_CH(2), .OUT_SHIFT(15), .CLEAR_ON_LAST(1)) dut2 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(v2), .s00_axis_tready(r2), .s00_axis_tdata(in_data),
        .s00_axis_tstrb(in_strb), .s00_axis_tlast(in_last),
        .m00_axis_tvalid(mv2), .m00_axis_tready(mr2), .m00_axis_tdata(md2),
        .m00_axis_tstrb(ms2), .m00_axis_tlast(ml2), .m00_axis_tuser(mu2)
    );

    logic        cur_ready, cur_mvalid;
    logic [37:0] cur_pkt;
    assign cur_ready  = sel ? r2 : r1;
    assign cur_mvalid = sel ? mv2 : mv1;
    assign cur_pkt    = sel ? {ml2, mu2, ms2, md2} : {ml1, mu1, ms1, md1};

    int errors = 0;
    int checks = 0;

    // Packet layout: {tlast, tuser, tstrb[3:0], imag[15:0], real[15:0]}
    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];

    int          m_nch;
    int          m_ch;
    logic [31:0] m_hist[16];
    bit          m_hv[16];
    bit          stall_prev;
    logic [37:0] held_pkt;

    task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint clamp16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset(input int nch);
        m_nch = nch;
        m_ch  = 0;
        for (int i = 0; i < 16; i++) begin
            m_hv[i]   = 1'b0;
            m_hist[i] = '0;
        end
        exp_q.delete();
        stall_prev = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic l, input logic [3:0] s);
        longint a, b, c, e, re, im;
        logic [63:0] re_v, im_v;
        logic [31:0] ch_v;
        a = longint'($signed(d[15:0]));
        b = longint'($signed(d[31:16]));
        c = longint'($signed(m_hist[m_ch][15:0]));
        e = longint'($signed(m_hist[m_ch][31:16]));
        if (m_hv[m_ch]) begin
            re = clamp16((a * c + b * e) >>> 15);
            im = clamp16((b * c - a * e) >>> 15);
        end else begin
            re = 0;
            im = 0;
        end
        re_v = re;
        im_v = im;
        ch_v = m_ch;
        exp_q.push_back({l, ch_v[0], s, im_v[15:0], re_v[15:0]});
        m_hist[m_ch] = d;
        m_hv[m_ch]   = 1'b1;
        if (l) begin
            for (int i = 0; i < 16; i++) m_hv[i] = 1'b0;
            m_ch = 0;
        end else begin
            m_ch = (m_ch + 1) % m_nch;
        end
    endtask

    task automatic check_outputs();
        if (stall_prev) begin
            chk("hold_valid", {37'd0, cur_mvalid}, 38'd1);
            chk("hold_data", cur_pkt, held_pkt);
        end
        if (cur_mvalid && out_ready) begin
            chk_int("out_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) chk("out_beat", cur_pkt, exp_q.pop_front());
            obs_q.push_back(cur_pkt);
        end
        stall_prev = cur_mvalid && !out_ready;
        held_pkt   = cur_pkt;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic [3:0] s, input logic mr, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        in_strb   = s;
        out_ready = mr;
        #1;
        check_outputs();
        acc = v && cur_ready;
        if (acc) model_accept(d, l, s);
        @(posedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [3:0] s, input logic mr);
        logic acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, d, l, s, mr, acc);
            n++;
        end
        chk("send_accept", {37'd0, acc}, 38'd1);
    endtask

    task automatic drain();
        logic acc;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step(1'b0, 32'd0, 1'b0, 4'd0, 1'b1, acc);
            n++;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 4'd0, 1'b1, acc);
        chk_int("drain_empty", exp_q.size(), 0);
        stall_prev = 1'b0;
    endtask

    initial begin
        logic        acc, pend, pl;
        logic [31:0] pd;
        logic [3:0]  ps;
        int          sent, cyc;

        // Clock/reset
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_strb = '0; out_ready = 1'b1;
        model_reset(1);
        #1;
        chk("rst_tready", {37'd0, r1}, 38'd0);
        chk("rst_mvalid", {37'd0, mv1}, 38'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_tready", {37'd0, r1}, 38'd1);
        chk("post_rst_outputs", {mv1, ml1, mu1, ms1, md1}, 39'd0);

        // NUM_CH=1: prev=(16384,0), cur=(0,16384)
        obs_q.delete();
        send(32'h0000_4000, 1'b0, 4'hF, 1'b1);
        send(32'h4000_0000, 1'b0, 4'hF, 1'b1);
        drain();
        chk("ch1_first_zero", {6'd0, obs_q[0][31:0]}, 38'd0);
        chk("ch1_second_j8192", {6'd0, obs_q[1][31:0]}, {6'd0, 32'h2000_0000});

        // Saturation: two full-negative samples
        obs_q.delete();
        send(32'h8000_8000, 1'b0, 4'h3, 1'b1);
        send(32'h8000_8000, 1'b0, 4'hC, 1'b1);
        drain();
        chk("sat_real_max", {6'd0, obs_q[1][31:0]}, {6'd0, 32'h0000_7FFF});

        // NUM_CH=2 interleave A0,B0,A1,B1
        sel = 1'b1;
        model_reset(2);
        obs_q.delete();
        send(32'h0000_4000, 1'b0, 4'hF, 1'b1);
        send(32'h0000_4000, 1'b0, 4'hF, 1'b1);
        send(32'h4000_0000, 1'b0, 4'hF, 1'b1);
        send(32'h0000_4000, 1'b0, 4'hF, 1'b1);
        drain();
        chk("il_user0", {37'd0, obs_q[0][36]}, 38'd0);
        chk("il_user1", {37'd0, obs_q[1][36]}, 38'd1);
        chk("il_user2", {37'd0, obs_q[2][36]}, 38'd0);
        chk("il_user3", {37'd0, obs_q[3][36]}, 38'd1);
        chk("il_data0", {6'd0, obs_q[0][31:0]}, 38'd0);
        chk("il_data1", {6'd0, obs_q[1][31:0]}, 38'd0);
        chk("il_data2", {6'd0, obs_q[2][31:0]}, {6'd0, 32'h2000_0000});
        chk("il_data3", {6'd0, obs_q[3][31:0]}, {6'd0, 32'h0000_2000});

        // Clear on TLAST: beat 3 carries TLAST
        obs_q.delete();
        send(32'h1234_5678, 1'b0, 4'h1, 1'b1);
        send(32'h2468_0ACE, 1'b0, 4'h2, 1'b1);
        send(32'h0FF0_0FF0, 1'b1, 4'h4, 1'b1);
        send(32'h1111_2222, 1'b0, 4'h8, 1'b1);
        drain();
        chk("last_beat4_zero", {6'd0, obs_q[3][31:0]}, 38'd0);
        chk("last_beat4_user", {37'd0, obs_q[3][36]}, 38'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("last_flag%0d", i), {37'd0, obs_q[i][37]}, {37'd0, (i == 2)});
        end

        // Random stream with random downstream backpressure
        pend = 1'b0; sent = 0; cyc = 0;
        pd = '0; pl = 1'b0; ps = '0;
        while ((sent < 64 || exp_q.size() != 0) && cyc < 3000) begin
            if (!pend && sent < 64 && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pd   = ($urandom_range(0, 7) == 0) ? 32'h8000_8000 : $urandom();
                pl   = ($urandom_range(0, 7) == 0);
                ps   = 4'($urandom_range(0, 15));
            end
            step(pend, pd, pl, ps, ($urandom_range(0, 2) != 0), acc);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk_int("rand_sent", sent, 64);
        drain();

        // Reset with two beats in flight on the NUM_CH=1 instance
        sel = 1'b0;
        send(32'h0100_0200, 1'b0, 4'hF, 1'b0);
        send(32'h0300_0400, 1'b0, 4'hF, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mvalid", {37'd0, mv1}, 38'd0);
        chk("midrst_tready", {37'd0, r1}, 38'd0);
        model_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        send(32'h4000_4000, 1'b0, 4'hF, 1'b1);
        drain();
        chk_int("midrst_out_count", obs_q.size(), 1);
        chk("midrst_first_zero", {6'd0, obs_q[0][31:0]}, 38'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
